// File: rtl/lrrr_pkg.sv
// Shared types and constants for the Lrrr boss sequencer.
package lrrr_pkg;

  localparam int unsigned FRAME_W  = 8;
  localparam int unsigned HEALTH_W = 4;
  localparam int unsigned LFSR_W   = 8;

  // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_ACTIVE,
    ST_HIT,
    ST_DEAD
  } state_e;

endpackage

// File: rtl/lrrr_lfsr.sv
// 8-bit Fibonacci LFSR stepping once per enable pulse; only built when
// LRRR_RANDOM_TOGGLE_EN is defined.
`ifdef LRRR_RANDOM_TOGGLE_EN
module lrrr_lfsr
  import lrrr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  // A nonzero seed with maximal-length taps never reaches the all-zero state
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule
`endif

// File: rtl/lrrr_controller.sv
// Lrrr boss life-cycle sequencer: spawn delay, flight toggles, hits, death.
// Optional LRRR_RANDOM_TOGGLE_EN randomises the vertical toggle period.
module lrrr_controller
  import lrrr_pkg::*;
#(
  parameter int unsigned SPAWN_DELAY   = 60,
  parameter int unsigned TOGGLE_PERIOD = 45,
  parameter int unsigned HIT_FRAMES    = 8,
  parameter int unsigned LRRR_HEALTH   = 5
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                gameStart,
  input  logic                collision,
  output logic                waiting,
  output logic                toggleY,
  output logic                lrrrAlive,
  output logic                hitFlash,
  output logic                scorePulse,
  output logic [HEALTH_W-1:0] hitsLeft
);

  localparam logic [FRAME_W-1:0]  SPAWN_LAST  = FRAME_W'(SPAWN_DELAY - 1);
  localparam logic [FRAME_W-1:0]  HIT_LAST    = FRAME_W'(HIT_FRAMES - 1);
  localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(LRRR_HEALTH);

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [FRAME_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [HEALTH_W-1:0] hits_left_q, hits_left_d;
  logic                collision_prev_q;
  logic                waiting_q, waiting_d;
  logic                toggle_y_q, toggle_y_d;
  logic                alive_q, alive_d;
  logic                hit_flash_q, hit_flash_d;
  logic                score_q, score_d;

  logic [FRAME_W-1:0]  period_c;
  logic                flying_c;
  logic                hit_edge_c;
  logic                toggle_evt_c;

  assign flying_c     = (state_q == ST_ACTIVE) || (state_q == ST_HIT);
  assign hit_edge_c   = collision && !collision_prev_q;
  assign toggle_evt_c = startOfFrame && flying_c &&
                        (frame_cnt_q == period_c - FRAME_W'(1));

`ifdef LRRR_RANDOM_TOGGLE_EN
  localparam int unsigned HALF_PERIOD = TOGGLE_PERIOD / 2;

  logic [LFSR_W-1:0]  lfsr;
  logic [FRAME_W-1:0] period_q, period_d;

  lrrr_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (resetN),
    .en    (startOfFrame),
    .lfsr  (lfsr)
  );

  // Next period is drawn at each toggle from the low five LFSR bits
  always_comb begin
    period_d = period_q;
    if (toggle_evt_c)
      period_d = FRAME_W'(HALF_PERIOD) +
                 FRAME_W'(32'(lfsr & LFSR_W'(8'h1F)) % HALF_PERIOD);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) period_q <= FRAME_W'(TOGGLE_PERIOD);
    else         period_q <= period_d;
  end

  assign period_c = period_q;
`else
  assign period_c = FRAME_W'(TOGGLE_PERIOD);
`endif

  // Next-state, counters and registered-output decode
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    hits_left_d = hits_left_q;
    toggle_y_d  = toggle_y_q;

    if (startOfFrame) toggle_y_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gameStart) begin
          state_d     = ST_DELAY;
          frame_cnt_d = '0;
        end
      end
      ST_DELAY: begin
        if (startOfFrame) begin
          if (frame_cnt_q == SPAWN_LAST) begin
            state_d     = ST_ACTIVE;
            frame_cnt_d = '0;
            hits_left_d = HEALTH_INIT;
          end else begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
          end
        end
      end
      ST_ACTIVE, ST_HIT: begin
        if (toggle_evt_c) begin
          toggle_y_d  = 1'b1;
          frame_cnt_d = '0;
        end else if (startOfFrame) begin
          frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end
        if (state_q == ST_ACTIVE) begin
          if (hit_edge_c && (hits_left_q != '0)) begin
            hits_left_d = hits_left_q - HEALTH_W'(1);
            if (hits_left_q == HEALTH_W'(1)) begin
              state_d = ST_DEAD;
            end else begin
              state_d   = ST_HIT;
              hit_cnt_d = '0;
            end
          end
        end else if (startOfFrame) begin
          if (hit_cnt_q == HIT_LAST) state_d = ST_ACTIVE;
          else                       hit_cnt_d = hit_cnt_q + FRAME_W'(1);
        end
      end
      ST_DEAD: begin
        state_d     = ST_DELAY;
        frame_cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they change with it
    alive_d     = (state_d == ST_ACTIVE) || (state_d == ST_HIT);
    waiting_d   = !alive_d;
    hit_flash_d = (state_d == ST_HIT);
    score_d     = (state_d == ST_DEAD);
    if (waiting_d) toggle_y_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q          <= ST_IDLE;
      frame_cnt_q      <= '0;
      hit_cnt_q        <= '0;
      hits_left_q      <= HEALTH_INIT;
      collision_prev_q <= 1'b0;
      waiting_q        <= 1'b1;
      toggle_y_q       <= 1'b0;
      alive_q          <= 1'b0;
      hit_flash_q      <= 1'b0;
      score_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      frame_cnt_q      <= frame_cnt_d;
      hit_cnt_q        <= hit_cnt_d;
      hits_left_q      <= hits_left_d;
      collision_prev_q <= collision;
      waiting_q        <= waiting_d;
      toggle_y_q       <= toggle_y_d;
      alive_q          <= alive_d;
      hit_flash_q      <= hit_flash_d;
      score_q          <= score_d;
    end
  end

  assign waiting    = waiting_q;
  assign toggleY    = toggle_y_q;
  assign lrrrAlive  = alive_q;
  assign hitFlash   = hit_flash_q;
  assign scorePulse = score_q;
  assign hitsLeft   = hits_left_q;

endmodule

// File: tb/tb_lrrr_controller.sv
// Self-checking bench for lrrr_controller: vector table plus frame-level
// sequences, expected outputs queued at drive time and popped after the edge.
module tb_lrrr_controller;

  localparam int unsigned SPAWN = 60;
  localparam int unsigned TPER  = 45;
  localparam int unsigned HITF  = 8;
  localparam int unsigned HLTH  = 5;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       gameStart = 1'b0;
  logic       collision = 1'b0;
  logic       waiting, toggleY, lrrrAlive, hitFlash, scorePulse;
  logic [3:0] hitsLeft;

  lrrr_controller #(
    .SPAWN_DELAY   (SPAWN),
    .TOGGLE_PERIOD (TPER),
    .HIT_FRAMES    (HITF),
    .LRRR_HEALTH   (HLTH)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .gameStart    (gameStart),
    .collision    (collision),
    .waiting      (waiting),
    .toggleY      (toggleY),
    .lrrrAlive    (lrrrAlive),
    .hitFlash     (hitFlash),
    .scorePulse   (scorePulse),
    .hitsLeft     (hitsLeft)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w, t, a, f, s;
    logic [3:0] h;
  } exp_t;

  typedef struct packed {
    logic sof, gs, col;
    exp_t e;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Expected outputs after the next edge, set by the sequence before each step
  logic       e_w = 1'b1, e_t = 1'b0, e_a = 1'b0, e_f = 1'b0, e_s = 1'b0;
  logic [3:0] e_h = 4'd5;
  bit         tog_run = 1'b0;
  int         act_frames = 0;

  task automatic compare(input string name);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty at vector %0d", name, n_vec);
      return;
    end
    e = exp_q.pop_front();
    if ({waiting, toggleY, lrrrAlive, hitFlash, scorePulse, hitsLeft} !== e) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got waiting=%b toggleY=%b alive=%b flash=%b score=%b hits=%0d, required waiting=%b toggleY=%b alive=%b flash=%b score=%b hits=%0d",
               name, n_vec, waiting, toggleY, lrrrAlive, hitFlash, scorePulse, hitsLeft,
               e.w, e.t, e.a, e.f, e.s, e.h);
    end
  endtask

  task automatic step(input logic sof, input logic gs, input logic col, input string name);
    @(negedge clk);
    startOfFrame = sof;
    gameStart    = gs;
    collision    = col;
    if (sof && tog_run) begin
      act_frames++;
      e_t = ((act_frames % TPER) == 0);
    end
    exp_q.push_back({e_w, e_t, e_a, e_f, e_s, e_h});
    @(posedge clk);
    #1;
    compare(name);
  endtask

  task automatic frame(input logic col, input string name);
    step(1'b1, 1'b0, col, name);
    step(1'b0, 1'b0, col, name);
  endtask

  task automatic flash_frames(input string name);
    for (int j = 1; j <= HITF; j++) begin
      if (j == HITF) e_f = 1'b0;
      frame(1'b1, name);
    end
  endtask

  task automatic reset_check(input string name);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    e_w = 1'b1; e_t = 1'b0; e_a = 1'b0; e_f = 1'b0; e_s = 1'b0; e_h = 4'(HLTH);
    tog_run = 1'b0;
    act_frames = 0;
    exp_q.push_back({e_w, e_t, e_a, e_f, e_s, e_h});
    compare(name);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{sof: 1'b0, gs: 1'b0, col: 1'b0, e: '{w: 1'b1, t: 1'b0, a: 1'b0, f: 1'b0, s: 1'b0, h: 4'd5}};
    tbl[1] = '{sof: 1'b1, gs: 1'b0, col: 1'b0, e: '{w: 1'b1, t: 1'b0, a: 1'b0, f: 1'b0, s: 1'b0, h: 4'd5}};
    tbl[2] = '{sof: 1'b0, gs: 1'b1, col: 1'b0, e: '{w: 1'b1, t: 1'b0, a: 1'b0, f: 1'b0, s: 1'b0, h: 4'd5}};
    tbl[3] = '{sof: 1'b1, gs: 1'b1, col: 1'b0, e: '{w: 1'b1, t: 1'b0, a: 1'b0, f: 1'b0, s: 1'b0, h: 4'd5}};
    tbl[4] = '{sof: 1'b0, gs: 1'b1, col: 1'b1, e: '{w: 1'b1, t: 1'b0, a: 1'b0, f: 1'b0, s: 1'b0, h: 4'd5}};
    tbl[5] = '{sof: 1'b1, gs: 1'b0, col: 1'b1, e: '{w: 1'b1, t: 1'b0, a: 1'b0, f: 1'b0, s: 1'b0, h: 4'd5}};

    #3;
    reset_check("reset");

    // IDLE, start, early DELAY frames; collision rises and stays high
    for (int i = 0; i < 6; i++) begin
      {e_w, e_t, e_a, e_f, e_s, e_h} = tbl[i].e;
      step(tbl[i].sof, tbl[i].gs, tbl[i].col, "table");
    end

    // Two DELAY frames seen in the table; 57 more keep the boss parked
    for (int k = 0; k < SPAWN - 3; k++) frame(1'b1, "delay_count");
    e_w = 1'b0; e_a = 1'b1; e_h = 4'(HLTH);
    step(1'b1, 1'b0, 1'b1, "spawn");
    tog_run = 1'b1; act_frames = 0;

    // Flight with collision held high from DELAY: toggles, no hit
    for (int k = 1; k <= 2 * TPER + 1; k++) frame(1'b1, "toggle_held_col");

    // Single hit, then a second edge during the flash is ignored
    step(1'b0, 1'b0, 1'b0, "col_fall");
    e_f = 1'b1; e_h = 4'd4;
    step(1'b0, 1'b0, 1'b1, "hit_1");
    for (int j = 1; j <= HITF; j++) begin
      if (j == HITF) e_f = 1'b0;
      step(1'b1, 1'b0, 1'b1, "hit_flash");
      if (j == 3) begin
        step(1'b0, 1'b0, 1'b0, "flash_col_low");
        step(1'b0, 1'b0, 1'b1, "flash_col_ignored");
      end
      step(1'b0, 1'b0, 1'b1, "hit_flash");
    end

    // Hit coinciding with startOfFrame
    step(1'b0, 1'b0, 1'b0, "col_fall");
    e_f = 1'b1; e_h = 4'd3;
    step(1'b1, 1'b0, 1'b1, "hit_with_sof");
    flash_frames("flash_2");

    step(1'b0, 1'b0, 1'b0, "col_fall");
    e_f = 1'b1; e_h = 4'd2;
    step(1'b0, 1'b0, 1'b1, "hit_3");
    flash_frames("flash_3");

    step(1'b0, 1'b0, 1'b0, "col_fall");
    e_f = 1'b1; e_h = 4'd1;
    step(1'b0, 1'b0, 1'b1, "hit_4");
    flash_frames("flash_4");

    // Fatal hit: one-clock score pulse, then respawn delay with gameStart held
    step(1'b0, 1'b0, 1'b0, "col_fall");
    e_w = 1'b1; e_a = 1'b0; e_f = 1'b0; e_s = 1'b1; e_h = 4'd0; e_t = 1'b0;
    tog_run = 1'b0;
    step(1'b0, 1'b0, 1'b1, "kill");
    e_s = 1'b0;
    step(1'b0, 1'b1, 1'b1, "dead_to_delay");
    for (int k = 0; k < SPAWN - 1; k++) begin
      step(1'b1, 1'b1, 1'b1, "respawn_delay");
      step(1'b0, 1'b1, 1'b1, "respawn_delay");
    end
    e_w = 1'b0; e_a = 1'b1; e_h = 4'(HLTH);
    step(1'b1, 1'b1, 1'b1, "respawn");
    tog_run = 1'b1; act_frames = 0;
    frame(1'b1, "active_again");

    // Reset while flashing, then confirm gameStart is required
    step(1'b0, 1'b0, 1'b0, "col_fall");
    e_f = 1'b1; e_h = 4'd4;
    step(1'b0, 1'b0, 1'b1, "hit_pre_reset");
    frame(1'b1, "flash_pre_reset");
    reset_check("reset_mid_hit");
    step(1'b1, 1'b0, 1'b0, "idle_after_reset");
    step(1'b0, 1'b0, 1'b1, "idle_after_reset");
    step(1'b1, 1'b0, 1'b0, "idle_after_reset");
    step(1'b0, 1'b1, 1'b0, "restart");
    step(1'b1, 1'b0, 1'b0, "restart_delay");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lrrr_controller.md
Name: lrrr_controller

Overview:
Upstream sequencer for the Lrrr boss movement stage; generates its `waiting` and `toggleY` controls.
- Tracks boss life cycle: spawn delay, active flight, hit flash, death, respawn.
- Counts player-missile hits against a health budget.
- Emits a one-cycle score pulse when the boss dies.
- All timing is in frames, counted on startOfFrame pulses.

Parameters:
SPAWN_DELAY, 60, frames spent in DELAY before the boss is released (1..255)
TOGGLE_PERIOD, 45, frames between vertical-direction toggles while ACTIVE (2..255)
HIT_FRAMES, 8, frames of hit flash after a non-fatal hit (1..255)
LRRR_HEALTH, 5, hits needed to kill the boss (1..15)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clock pulse at start of each frame
gameStart  in  1  level; leaves IDLE when high
collision  in  1  level; boss/missile overlap, edge-detected internally
waiting  out  1  high = boss parked (drives movement stage hold/reinit)
toggleY  out  1  vertical-direction toggle request, one frame wide
lrrrAlive  out  1  high in ACTIVE and HIT
hitFlash  out  1  high in HIT (drawing stage blinks sprite)
scorePulse  out  1  one-clock pulse on death
hitsLeft  out  4  remaining health

Behaviour:
Reset (async, resetN low):
- state = IDLE; waiting = 1; toggleY = 0; lrrrAlive = 0; hitFlash = 0; scorePulse = 0.
- hitsLeft = LRRR_HEALTH; frameCnt = 0; collision_d = 0.

FSM states IDLE, DELAY, ACTIVE, HIT, DEAD. Registered outputs take effect the clock after the transition.
- IDLE: waiting = 1. gameStart = 1 -> DELAY; frameCnt = 0.
- DELAY: waiting = 1. frameCnt increments on each startOfFrame. When frameCnt reaches SPAWN_DELAY-1 on a startOfFrame -> ACTIVE; frameCnt = 0; hitsLeft = LRRR_HEALTH.
- ACTIVE: waiting = 0; lrrrAlive = 1.
  - frameCnt increments per startOfFrame.
  - When frameCnt reaches TOGGLE_PERIOD-1 on a startOfFrame: toggleY = 1, frameCnt = 0.
  - toggleY clears on the next startOfFrame, so it is high for exactly one frame. This guarantees the downstream edge detector sees it.
- Hit detection: collision rising edge (collision = 1 and collision_d = 0) in ACTIVE:
  - hitsLeft decrements.
  - If hitsLeft was 1 -> DEAD.
  - Otherwise -> HIT, with hitCnt = 0.
- HIT: waiting = 0; hitFlash = 1.
  - Collisions are ignored (invulnerability).
  - The toggle counter keeps running.
  - hitCnt counts startOfFrame; at HIT_FRAMES-1 -> ACTIVE.
- DEAD: scorePulse = 1 for exactly the first clock in DEAD. waiting = 1; toggleY forced 0; frameCnt = 0; next clock -> DELAY (respawn).

Boundary and simultaneous events:
- collision edge and toggle on the same clock: both take effect.
- collision edge and startOfFrame on the same clock: the hit is processed and the frame still counts.
- gameStart in DELAY, ACTIVE, HIT or DEAD: ignored. gameStart held high does not restart anything.
- collision held high across ACTIVE entry: not a hit (edge only). collision_d updates every clock in all states.
- hitsLeft never underflows; it saturates at 0 in DEAD and reloads on DELAY -> ACTIVE.
- waiting drops in the same clock lrrrAlive rises, so the downstream stage reloads initial speed cleanly.
- resetN low mid-operation: immediate return to reset values, regardless of state.

Optional Feature:
LRRR_RANDOM_TOGGLE_EN
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 at reset) advances on every startOfFrame.
  - On each toggle event, the next toggle period becomes TOGGLE_PERIOD/2 + (lfsr[4:0] mod TOGGLE_PERIOD/2).
  - The LFSR never reaches 0.
- Undefined: fixed TOGGLE_PERIOD; no LFSR logic is synthesized.

Decomposition:
Package lrrr_pkg holds:
- the state enum (IDLE, DELAY, ACTIVE, HIT, DEAD);
- frame counter width (8) and health width (4) constants;
- the LFSR seed and tap constants.

Sub-module lrrr_lfsr (8-bit, enable = startOfFrame) is instantiated only under LRRR_RANDOM_TOGGLE_EN. Everything else is a single FSM module.

Test Plan:
- Reset then gameStart=1, 60 startOfFrame pulses -> waiting falls after the 60th; lrrrAlive=1; hitsLeft=5.
- ACTIVE with no collision, 90 frames -> toggleY high for exactly 1 frame after frames 45 and 90; never high for 2 consecutive frames.
- Single collision pulse in ACTIVE -> hitsLeft 5->4; hitFlash high 8 frames; second collision during flash ignored (hitsLeft stays 4).
- Five spaced collisions -> on the 5th: scorePulse high exactly 1 clock; waiting=1; lrrrAlive=0; after 60 more frames ACTIVE again with hitsLeft=5.
- collision held high from DELAY into ACTIVE -> no decrement until it falls and rises again.
- resetN asserted mid-HIT -> same cycle: waiting=1, hitFlash=0, hitsLeft=5, state IDLE; gameStart needed to restart.
